spi_host_win_arb: RTL and testbench

SPI_HOST_WIN_ARB -- requirements
Module: spi_host_win_arb

---
 rtl/spi_host_pkg.sv | 26 ++
 rtl/spi_host_win_rr_pick.sv | 41 ++++
 rtl/spi_host_win_arb.sv | 115 +++++++++++
 tb/tb_spi_host_win_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_host_pkg.sv
// Shared types for the SPI host window arbiter: arbiter state, default burst
// limit and the default register-bus request/response structs.
package spi_host_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } win_state_e;

  localparam int MaxBurstDefault = 4;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } win_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } win_rsp_t;

endpackage

// File: rtl/spi_host_win_rr_pick.sv
// Round-robin picker: first set bit of the valid vector at or after ptr,
// wrapping modulo NumReq. Produces both a one-hot grant and its index.
module spi_host_win_rr_pick #(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0]         valid,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic [NumReq-1:0]         grant,
  output logic [$clog2(NumReq)-1:0] idx
);

  localparam int IdxW = $clog2(NumReq);
  localparam int SumW = IdxW + 1;

  logic [NumReq-1:0] rot;
  logic [SumW-1:0]   sum;
  logic              found;

  // rot[j] is the valid bit of requester (ptr + j) mod NumReq
  assign rot = NumReq'({valid, valid} >> ptr);

  always_comb begin
    found = 1'b0;
    sum   = '0;
    for (int j = NumReq - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + SumW'(j);
      end
    end
    if (sum >= SumW'(NumReq)) begin
      sum = sum - SumW'(NumReq);
    end
    idx = sum[IdxW-1:0];
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_onehot
    assign grant[gi] = found && (idx == IdxW'(gi));
  end

endmodule

// File: rtl/spi_host_win_arb.sv
// Arbitrates several register-bus requesters onto the single SPI host TX/RX
// window, letting one owner keep the window for up to MaxBurst accesses.
module spi_host_win_arb
  import spi_host_pkg::*;
#(
  parameter type reg_req_t = win_req_t,
  parameter type reg_rsp_t = win_rsp_t,
  parameter int  NumReq    = 2,
  parameter int  MaxBurst  = MaxBurstDefault
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  reg_req_t                  req_i [NumReq],
  output reg_rsp_t                  rsp_o [NumReq],
  output reg_req_t                  win_req_o,
  input  reg_rsp_t                  win_rsp_i,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      locked_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);

  win_state_e      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumReq-1:0] valid_vec;
  logic [NumReq-1:0] pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   grant_idx;
  logic              grant_valid;
  logic              handshake;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_valid
    assign valid_vec[gi] = req_i[gi].valid;
  end

  spi_host_win_rr_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .valid (valid_vec),
    .ptr   (ptr_q),
    .grant (pick_onehot),
    .idx   (pick_idx)
  );

  // While locked only the owner may reach the window; a dropped owner
  // forwards nothing and releases the lock on the next edge.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      grant_valid = valid_vec[owner_q];
      grant_idx   = owner_q;
    end else begin
      grant_valid = |pick_onehot;
      grant_idx   = pick_idx;
    end
    win_req_o = grant_valid ? req_i[grant_idx] : '0;
  end

  assign handshake = grant_valid & win_rsp_i.ready;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_rsp
    assign rsp_o[gi] = (grant_valid && (grant_idx == IdxW'(gi))) ? win_rsp_i : '0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          owner_d = grant_idx;
          ptr_d   = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
          if (MaxBurst > 1) begin
            state_d = ST_LOCKED;
            cnt_d   = CntW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!grant_valid) begin
          state_d = ST_IDLE;
        end else if (handshake) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(MaxBurst)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner_o  = owner_q;
  assign locked_o = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_spi_host_win_arb.sv
// Bench for spi_host_win_arb: two instances (MaxBurst 4 and 1, three requesters)
// checked every cycle against a burst-budget model, plus directed literal checks.
module tb_spi_host_win_arb;
  import spi_host_pkg::*;

  localparam int NR  = 3;
  localparam int MB0 = 4;
  localparam int MB1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  win_req_t req_m  [2][NR];
  win_rsp_t rsp_m  [2][NR];
  win_rsp_t wrsp_m [2];
  win_req_t req_a [NR], req_b [NR];
  win_rsp_t rsp_a [NR], rsp_b [NR];
  win_req_t wreq_a, wreq_b;
  logic [1:0] own_a, own_b;
  logic lock_a, lock_b;

  for (genvar gi = 0; gi < NR; gi++) begin : g_conn
    assign req_a[gi]    = req_m[0][gi];
    assign req_b[gi]    = req_m[1][gi];
    assign rsp_m[0][gi] = rsp_a[gi];
    assign rsp_m[1][gi] = rsp_b[gi];
  end

  spi_host_win_arb #(.reg_req_t(win_req_t), .reg_rsp_t(win_rsp_t), .NumReq(NR), .MaxBurst(MB0)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .rsp_o(rsp_a),
    .win_req_o(wreq_a), .win_rsp_i(wrsp_m[0]), .owner_o(own_a), .locked_o(lock_a));

  spi_host_win_arb #(.reg_req_t(win_req_t), .reg_rsp_t(win_rsp_t), .NumReq(NR), .MaxBurst(MB1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .rsp_o(rsp_b),
    .win_req_o(wreq_b), .win_rsp_i(wrsp_m[1]), .owner_o(own_b), .locked_o(lock_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: owner, rr pointer and how many burst beats the owner still has left.
  int maxb    [2] = '{MB0, MB1};
  int m_left  [2] = '{0, 0};
  int m_owner [2] = '{0, 0};
  int m_ptr   [2] = '{0, 0};

  function automatic int pick(input int m);
    if (m_left[m] > 0) return req_m[m][m_owner[m]].valid ? m_owner[m] : -1;
    for (int off = 0; off < NR; off++) begin
      if (req_m[m][(m_ptr[m] + off) % NR].valid) return (m_ptr[m] + off) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    for (int m = 0; m < 2; m++) begin
      g = pick(m);
      if (rst) begin
        m_left[m] = 0; m_owner[m] = 0; m_ptr[m] = 0;
      end else if (m_left[m] > 0) begin
        if (g < 0) m_left[m] = 0;
        else if (wrsp_m[m].ready) m_left[m] = m_left[m] - 1;
      end else if (g >= 0 && wrsp_m[m].ready) begin
        m_owner[m] = g;
        m_ptr[m]   = (g + 1) % NR;
        m_left[m]  = maxb[m] - 1;
      end
    end
  end

  bit acc   [2][NR];
  int waitc [2][NR];
  int log0 [$];
  int log1 [$];

  always @(negedge clk) begin
    win_req_t act_req, exp_req;
    win_rsp_t exp_rsp;
    int g, owner_act;
    bit lock_act, hs_any;
    for (int m = 0; m < 2; m++) begin
      act_req   = (m == 0) ? wreq_a : wreq_b;
      owner_act = (m == 0) ? int'(own_a) : int'(own_b);
      lock_act  = (m == 0) ? lock_a : lock_b;
      g = pick(m);
      if (g >= 0) exp_req = req_m[m][g];
      else exp_req = '0;
      chk(act_req === exp_req, $sformatf("win_req_o inst%0d", m), act_req, exp_req);
      for (int i = 0; i < NR; i++) begin
        exp_rsp = (g == i) ? wrsp_m[m] : '0;
        chk(rsp_m[m][i] === exp_rsp, $sformatf("rsp_o[%0d] inst%0d", i, m), rsp_m[m][i], exp_rsp);
      end
      chk(owner_act == m_owner[m], $sformatf("owner_o inst%0d", m), owner_act, m_owner[m]);
      chk(lock_act == (m_left[m] > 0), $sformatf("locked_o inst%0d", m), lock_act, m_left[m] > 0);
      hs_any = 1'b0;
      for (int i = 0; i < NR; i++) begin
        acc[m][i] = req_m[m][i].valid && rsp_m[m][i].ready;
        if (acc[m][i]) begin
          hs_any = 1'b1;
          if (m == 0) log0.push_back(i);
          else log1.push_back(i);
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (rst || !req_m[m][i].valid) waitc[m][i] = 0;
        else if (acc[m][i]) begin
          chk(waitc[m][i] <= (NR - 1) * maxb[m], $sformatf("fairness req%0d inst%0d", i, m),
              waitc[m][i], (NR - 1) * maxb[m]);
          waitc[m][i] = 0;
        end else if (hs_any) waitc[m][i]++;
      end
    end
  end

  // Stimulus: requesters hold valid and payload until accepted.
  bit rnd_mode = 1'b0;
  bit force_err = 1'b0;
  bit wrdy = 1'b1;
  logic [NR-1:0] want = '0;

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(req_m[m][i].valid && !acc[m][i])) begin
          req_m[m][i].valid = rnd_mode ? ($urandom_range(0, 99) < 65) : want[i];
          req_m[m][i].write = 1'($urandom);
          req_m[m][i].addr  = $urandom;
          req_m[m][i].wdata = $urandom;
          req_m[m][i].wstrb = 4'($urandom);
        end
      end
      wrsp_m[m].ready = rnd_mode ? ($urandom_range(0, 3) != 0) : wrdy;
      wrsp_m[m].error = force_err ? 1'b1 : (rnd_mode ? 1'($urandom) : 1'b0);
      wrsp_m[m].rdata = force_err ? 32'hDEADBEEF : $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset(input logic [NR-1:0] w);
    rst  = 1'b1;
    want = w;
    wrdy = 1'b1;
    step();
    @(negedge clk);
    chk(own_a == 2'd0, "reset owner_o a", own_a, 0);
    chk(lock_a == 1'b0, "reset locked_o a", lock_a, 0);
    chk(own_b == 2'd0, "reset owner_o b", own_b, 0);
    repeat (3) step();
    rst = 1'b0;
    log0.delete();
    log1.delete();
  endtask

  initial begin
    win_req_t cap;
    bit saw_lock_b;
    for (int m = 0; m < 2; m++) begin
      wrsp_m[m] = '0;
      for (int i = 0; i < NR; i++) req_m[m][i] = '0;
    end

    // Both requesters always valid: bursts of 4 alternate; MaxBurst=1 alternates per beat
    do_reset(3'b011);
    saw_lock_b = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (lock_b) saw_lock_b = 1'b1;
      step();
    end
    chk(log0.size() >= 16, "s1 handshake count", log0.size(), 16);
    for (int k = 0; k < 16 && k < log0.size(); k++)
      chk(log0[k] == (k / 4) % 2, $sformatf("s1 owner seq beat %0d", k), log0[k], (k / 4) % 2);
    for (int k = 0; k < 8 && k < log1.size(); k++)
      chk(log1[k] == k % 2, $sformatf("s5 owner seq beat %0d", k), log1[k], k % 2);
    chk(saw_lock_b == 1'b0, "s5 locked_o stays low", saw_lock_b, 0);

    // Requester 0 drops valid after two accesses
    do_reset(3'b011);
    step();
    want[0] = 1'b0;
    step();
    @(negedge clk);
    chk(lock_a == 1'b1, "s2 still locked on drop cycle", lock_a, 1);
    chk(wreq_a.valid == 1'b0, "s2 nothing forwarded on drop", wreq_a.valid, 0);
    step();
    @(negedge clk);
    chk(lock_a == 1'b0, "s2 lock released", lock_a, 0);
    chk(rsp_a[1].ready == 1'b1, "s2 requester 1 granted", rsp_a[1].ready, 1);

    // Window stalls for 3 cycles mid-burst
    do_reset(3'b011);
    step();
    wrdy = 1'b0;
    step();
    @(negedge clk);
    cap = wreq_a;
    chk(cap.valid == 1'b1, "s3 stalled request valid", cap.valid, 1);
    repeat (2) begin
      step();
      @(negedge clk);
      chk(wreq_a === cap, "s3 payload held", wreq_a, cap);
      chk(own_a == 2'd0, "s3 owner held", own_a, 0);
      chk(lock_a == 1'b1, "s3 lock held", lock_a, 1);
    end
    wrdy = 1'b1;
    repeat (4) step();
    chk(log0.size() >= 5, "s3 handshake count", log0.size(), 5);
    for (int k = 0; k < 5 && k < log0.size(); k++)
      chk(log0[k] == ((k == 4) ? 1 : 0), $sformatf("s3 owner seq beat %0d", k), log0[k], (k == 4) ? 1 : 0);

    // Reset while requester 1 owns the window with two beats done
    do_reset(3'b010);
    step();
    want = 3'b011;
    step();
    @(negedge clk);
    chk(lock_a == 1'b1, "s4 locked before reset", lock_a, 1);
    chk(own_a == 2'd1, "s4 owner before reset", own_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk(lock_a == 1'b0, "s4 lock abandoned", lock_a, 0);
    chk(own_a == 2'd0, "s4 owner after reset", own_a, 0);
    chk(rsp_a[0].ready == 1'b1, "s4 requester 0 first", rsp_a[0].ready, 1);

    // Error response reaches only the granted requester
    force_err = 1'b1;
    do_reset(3'b011);
    @(negedge clk);
    chk(rsp_a[0].error == 1'b1, "s6 error to grantee", rsp_a[0].error, 1);
    chk(rsp_a[0].rdata == 32'hDEADBEEF, "s6 rdata to grantee", rsp_a[0].rdata, 32'hDEADBEEF);
    chk(rsp_a[1] == '0, "s6 other rsp zero", rsp_a[1], 0);
    force_err = 1'b0;

    // Randomized traffic with occasional resets
    rnd_mode = 1'b1;
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
    end
    step();
    rst = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
